// File: rtl/axis_data_sink_checker.sv
// AXI4-Stream sink that checks beats against an incrementing pattern and TLAST framing, with an AXI4-Lite register bank.
// Latency: a beat is checked and counted on the accepting edge, visible to register reads one cycle later; err_irq lags ERR_CNT by one cycle.
// Backpressure: tready follows CTRL.EN (optionally gated by an LFSR when AXIS_SINK_BACKPRESSURE_EN is defined); AXI-Lite holds bvalid/rvalid until accepted.
module axis_data_sink_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int C_PKT_LEN_DEFAULT    = 8
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  // stream input
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  // AXI-Lite slave
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  // interrupt
  output logic                                err_irq
);

  localparam int TW = C_S_AXIS_TDATA_WIDTH;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t       state_q, state_d;
  logic         ctrl_en_q, ctrl_en_d;
  logic [15:0]  pkt_len_q, pkt_len_d;
  logic [31:0]  seed_q, seed_d;
  logic [31:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]  pkt_cnt_q, pkt_cnt_d;
  logic [15:0]  err_cnt_q, err_cnt_d;
  logic [TW-1:0] expected_q, expected_d;
  logic [15:0]  beat_idx_q, beat_idx_d;
  logic         err_irq_q, err_irq_d;
  logic         aw_rdy_q, aw_rdy_d;
  logic         bvalid_q, bvalid_d;
  logic         ar_rdy_q, ar_rdy_d;
  logic         rvalid_q, rvalid_d;
  logic [31:0]  rdata_q, rdata_d;

  logic         wr_en, rd_en, beat_acc, clr;
  logic [1:0]   wr_sel, rd_sel;
  logic [31:0]  ctrl_rd, ctrl_wr;
  logic [16:0]  idx_next;
  logic         at_end, data_bad, last_bad;
  logic         run_tready;

  // Inputs that carry no information for this sink (strobes, protection, byte offset).
  logic unused_ok;
  assign unused_ok = ^{s_axis_tstrb, s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[AW-3:0], s00_axi_araddr[AW-3:0]};

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  assign wr_en    = aw_rdy_q && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_en    = ar_rdy_q && s00_axi_arvalid;
  assign wr_sel   = s00_axi_awaddr[AW-1 -: 2];
  assign rd_sel   = s00_axi_araddr[AW-1 -: 2];
  assign beat_acc = s_axis_tvalid && s_axis_tready;
  assign ctrl_rd  = {pkt_len_q, 14'b0, 1'b0, ctrl_en_q};

`ifdef AXIS_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR x^16+x^14+x^13+x^11+1 advances only while running, throttling tready pseudo-randomly.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_RUN) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // LFSR register, restarts from its fixed seed on reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  assign run_tready = lfsr_q[0];
`else
  assign run_tready = 1'b1;
`endif

  assign s_axis_tready   = (state_q == ST_RUN) && run_tready;
  assign s00_axi_awready = aw_rdy_q;
  assign s00_axi_wready  = aw_rdy_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = ar_rdy_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign err_irq         = err_irq_q;

  // AXI-Lite handshakes: one-cycle ready pulses, responses held until the master takes them.
  always_comb begin
    aw_rdy_d = s00_axi_awvalid && s00_axi_wvalid && !bvalid_q && !aw_rdy_q;
    bvalid_d = bvalid_q;
    if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
    if (wr_en)                      bvalid_d = 1'b1;

    ar_rdy_d = s00_axi_arvalid && !rvalid_q && !ar_rdy_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      case (rd_sel)
        2'd0:    rdata_d = ctrl_rd;
        2'd1:    rdata_d = seed_q;
        2'd2:    rdata_d = beat_cnt_q;
        default: rdata_d = {pkt_cnt_q, err_cnt_q};
      endcase
    end
  end

  // Register writes, run/idle state and per-beat checking; CLR takes priority over a same-cycle beat.
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    pkt_len_d  = pkt_len_q;
    seed_d     = seed_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    expected_d = expected_q;
    beat_idx_d = beat_idx_q;
    clr        = 1'b0;
    ctrl_wr    = ctrl_rd;

    if (wr_en && wr_sel == 2'd0) begin
      ctrl_wr   = apply_strb(ctrl_rd, s00_axi_wdata, s00_axi_wstrb);
      ctrl_en_d = ctrl_wr[0];
      pkt_len_d = ctrl_wr[31:16];
      clr       = ctrl_wr[1];
    end
    if (wr_en && wr_sel == 2'd1) begin
      seed_d = apply_strb(seed_q, s00_axi_wdata, s00_axi_wstrb);
    end

    state_d = ctrl_en_d ? ST_RUN : ST_IDLE;

    // Position check: tlast is due exactly on the PKT_LEN-th beat; PKT_LEN=0 disables framing.
    idx_next = {1'b0, beat_idx_q} + 17'd1;
    at_end   = (pkt_len_q != 16'd0) && (idx_next == {1'b0, pkt_len_q});
    data_bad = (s_axis_tdata != expected_q);
    last_bad = (pkt_len_q != 16'd0) && (s_axis_tlast != at_end);

    if (clr) begin
      beat_cnt_d = 32'd0;
      pkt_cnt_d  = 16'd0;
      err_cnt_d  = 16'd0;
      beat_idx_d = 16'd0;
      expected_d = seed_q[TW-1:0];
    end else if (beat_acc) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      // Expected sequence free-runs: a bad beat does not resync it.
      expected_d = expected_q + {{(TW-1){1'b0}}, 1'b1};
      if ((data_bad || last_bad) && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (s_axis_tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (pkt_len_q == 16'd0 || s_axis_tlast || at_end) beat_idx_d = 16'd0;
      else                                               beat_idx_d = idx_next[15:0];
    end

    err_irq_d = (err_cnt_q != 16'd0);
  end

  // State register for the whole block.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      ctrl_en_q  <= 1'b0;
      pkt_len_q  <= 16'(C_PKT_LEN_DEFAULT);
      seed_q     <= 32'd0;
      beat_cnt_q <= 32'd0;
      pkt_cnt_q  <= 16'd0;
      err_cnt_q  <= 16'd0;
      expected_q <= '0;
      beat_idx_q <= 16'd0;
      err_irq_q  <= 1'b0;
      aw_rdy_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      ar_rdy_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      ctrl_en_q  <= ctrl_en_d;
      pkt_len_q  <= pkt_len_d;
      seed_q     <= seed_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      expected_q <= expected_d;
      beat_idx_q <= beat_idx_d;
      err_irq_q  <= err_irq_d;
      aw_rdy_q   <= aw_rdy_d;
      bvalid_q   <= bvalid_d;
      ar_rdy_q   <= ar_rdy_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axis_data_sink_checker.sv
// Testbench for axis_data_sink_checker: randomized beats against a behavioural model, register reads checked by a scoreboard monitor.
// Latency: register reads compared when rvalid&&rready is seen; status outputs compared against the model at quiet points.
// Backpressure: waits on tready/awready/arready/bvalid/rvalid are bounded and a timeout counts as an error.
module tb_axis_data_sink_checker;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tstrb;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [3:0]  s00_axi_awaddr, s00_axi_araddr;
  logic [2:0]  s00_axi_awprot, s00_axi_arprot;
  logic        s00_axi_awvalid, s00_axi_awready, s00_axi_wvalid, s00_axi_wready;
  logic [31:0] s00_axi_wdata, s00_axi_rdata;
  logic [3:0]  s00_axi_wstrb;
  logic [1:0]  s00_axi_bresp, s00_axi_rresp;
  logic        s00_axi_bvalid, s00_axi_bready, s00_axi_arvalid, s00_axi_arready;
  logic        s00_axi_rvalid, s00_axi_rready, err_irq;

  always #5 ACLK = ~ACLK;

  axis_data_sink_checker dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awprot(s00_axi_awprot),
    .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
    .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb),
    .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
    .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid), .s00_axi_bready(s00_axi_bready),
    .s00_axi_araddr(s00_axi_araddr), .s00_axi_arprot(s00_axi_arprot),
    .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
    .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp),
    .s00_axi_rvalid(s00_axi_rvalid), .s00_axi_rready(s00_axi_rready),
    .err_irq(err_irq)
  );

  int checks = 0;
  int errors = 0;
  bit saw_tready_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT never responded within the cycle budget", name);
  endtask

  // ---------------- reference model (register-level view) ----------------
  bit          m_en;
  logic [15:0] m_len;
  logic [31:0] m_seed, m_beat, m_exp;
  logic [15:0] m_pkt;
  int          m_err;
  int          m_pos;   // beats already seen in the current packet

  function automatic void model_reset();
    m_en = 0; m_len = 16'd8; m_seed = 0; m_beat = 0; m_exp = 0;
    m_pkt = 0; m_err = 0; m_pos = 0;
  endfunction

  function automatic void model_clear();
    m_beat = 0; m_pkt = 0; m_err = 0; m_pos = 0; m_exp = m_seed;
  endfunction

  function automatic void model_accept(input logic [31:0] data, input bit last);
    bit bad;
    bit due;
    bad = (data != m_exp);
    due = (m_len != 0) && (m_pos + 1 == int'(m_len));
    if (m_len != 0 && last != due) bad = 1;
    m_beat = m_beat + 1;
    m_exp  = m_exp + 1;
    if (bad && m_err < 65535) m_err++;
    if (last) m_pkt = m_pkt + 1;
    if (m_len == 0 || last || due) m_pos = 0;
    else                           m_pos++;
  endfunction

  function automatic logic [31:0] model_reg(input logic [3:0] addr);
    case (addr)
      4'h0:    return {m_len, 15'b0, m_en};
      4'h4:    return m_seed;
      4'h8:    return m_beat;
      default: return {m_pkt, m_err[15:0]};
    endcase
  endfunction

  // ---------------- read scoreboard ----------------
  logic [31:0] sb_exp[$];
  string       sb_name[$];

  always @(negedge ACLK) begin
    if (s00_axi_rvalid && s00_axi_rready) begin
      if (sb_exp.size() == 0) begin
        timeout_fail("unexpected_rvalid");
      end else begin
        check(sb_name.pop_front(), s00_axi_rdata, sb_exp.pop_front());
        check("rresp", {30'b0, s00_axi_rresp}, 32'd0);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic axil_write(input logic [3:0] addr, input logic [31:0] data,
                            input bit with_beat = 0, input logic [31:0] bdata = 0);
    int n;
    bit rdy;
    @(negedge ACLK);
    s00_axi_awaddr = addr; s00_axi_wdata = data; s00_axi_wstrb = 4'hF;
    s00_axi_awvalid = 1; s00_axi_wvalid = 1;
    n = 0;
    while (!s00_axi_awready && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      timeout_fail("awready");
      s00_axi_awvalid = 0; s00_axi_wvalid = 0;
      return;
    end
    if (with_beat) begin
      s_axis_tdata = bdata; s_axis_tlast = 0; s_axis_tvalid = 1;
    end
    rdy = s_axis_tready;
    @(posedge ACLK);
    if (with_beat && rdy && !(addr == 4'h0 && data[1])) model_accept(bdata, 0);
    if (addr == 4'h0) begin
      m_en = data[0]; m_len = data[31:16];
      if (data[1]) model_clear();
    end else if (addr == 4'h4) begin
      m_seed = data;
    end
    #1;
    s00_axi_awvalid = 0; s00_axi_wvalid = 0; s_axis_tvalid = 0; s00_axi_bready = 1;
    @(negedge ACLK);
    n = 0;
    while (!s00_axi_bvalid && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout_fail("bvalid");
    else         check("bresp", {30'b0, s00_axi_bresp}, 32'd0);
    @(posedge ACLK); #1;
    s00_axi_bready = 0;
  endtask

  task automatic axil_read(input logic [3:0] addr, input string name);
    int n;
    @(negedge ACLK);
    s00_axi_araddr = addr; s00_axi_arvalid = 1;
    sb_exp.push_back(model_reg(addr));
    sb_name.push_back(name);
    n = 0;
    while (!s00_axi_arready && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      timeout_fail("arready");
      s00_axi_arvalid = 0;
      sb_exp.delete(); sb_name.delete();
      return;
    end
    @(posedge ACLK); #1;
    s00_axi_arvalid = 0; s00_axi_rready = 1;
    @(negedge ACLK);
    n = 0;
    while (!s00_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      timeout_fail("rvalid");
      sb_exp.delete(); sb_name.delete();
    end
    @(posedge ACLK); #1;
    s00_axi_rready = 0;
  endtask

  task automatic send_beat(input logic [31:0] data, input bit last, input int max_gap = 0);
    int n;
    repeat ($urandom_range(0, max_gap)) @(negedge ACLK);
    @(negedge ACLK);
    s_axis_tdata = data; s_axis_tlast = last; s_axis_tvalid = 1;
    n = 0;
    while (!s_axis_tready && n < 200) begin
      saw_tready_low = 1;
      @(negedge ACLK);
      n++;
    end
    if (n >= 200) begin
      timeout_fail("tready");
      s_axis_tvalid = 0;
      return;
    end
    @(posedge ACLK);
    model_accept(data, last);
    #1;
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  // Random beat: usually correct, occasionally wrong data or wrong framing.
  task automatic send_random_beat();
    logic [31:0] d;
    bit          l;
    d = m_exp;
    if ($urandom_range(0, 7) == 0) d = m_exp ^ (32'h1 << $urandom_range(0, 31));
    if (m_len != 0) l = (m_pos + 1 == int'(m_len)) ^ ($urandom_range(0, 9) == 0);
    else            l = ($urandom_range(0, 3) == 0);
    send_beat(d, l, 2);
  endtask

  task automatic read_all(input string tag);
    axil_read(4'h0, {tag, "_ctrl"});
    axil_read(4'h4, {tag, "_seed"});
    axil_read(4'h8, {tag, "_beat"});
    axil_read(4'hC, {tag, "_stat"});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    ARESETN = 0;
    s_axis_tdata = 0; s_axis_tstrb = 4'hF; s_axis_tlast = 0; s_axis_tvalid = 0;
    s00_axi_awaddr = 0; s00_axi_awprot = 0; s00_axi_awvalid = 0;
    s00_axi_wdata = 0; s00_axi_wstrb = 0; s00_axi_wvalid = 0; s00_axi_bready = 0;
    s00_axi_araddr = 0; s00_axi_arprot = 0; s00_axi_arvalid = 0; s00_axi_rready = 0;
    model_reset();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_tready", {31'b0, s_axis_tready}, 32'd0);
    check("rst_err_irq", {31'b0, err_irq}, 32'd0);
    check("rst_bvalid", {31'b0, s00_axi_bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, s00_axi_rvalid}, 32'd0);
    check("rst_rdata", s00_axi_rdata, 32'd0);
    ARESETN = 1;
    read_all("reset");

    // Clean 8-beat packet from SEED=1.
    axil_write(4'h4, 32'd1);
    axil_write(4'h0, 32'h0008_0003);
`ifndef AXIS_SINK_BACKPRESSURE_EN
    @(negedge ACLK);
    check("run_tready", {31'b0, s_axis_tready}, 32'd1);
`endif
    for (int i = 1; i <= 8; i++) send_beat(32'(i), i == 8);
    axil_read(4'h8, "clean_beat");
    axil_read(4'hC, "clean_stat");
    check("clean_err_irq", {31'b0, err_irq}, 32'd0);

    // Bad data on beat 3; err_irq rises one cycle after the counter.
    axil_write(4'h0, 32'h0008_0003);
    for (int i = 1; i <= 8; i++) begin
      send_beat((i == 3) ? 32'hFF : 32'(i), i == 8);
      if (i == 3) begin
        @(negedge ACLK);
        check("irq_lag0", {31'b0, err_irq}, 32'd0);
        @(negedge ACLK);
        check("irq_lag1", {31'b0, err_irq}, 32'd1);
      end
    end
    axil_read(4'hC, "bad3_stat");
    check("bad3_err_irq", {31'b0, err_irq}, 32'd1);

    // PKT_LEN=4: early tlast then a missing tlast.
    axil_write(4'h0, 32'h0004_0003);
    send_beat(m_exp, 0);
    send_beat(m_exp, 1);
    for (int i = 0; i < 4; i++) send_beat(m_exp, 0);
    read_all("framing");

    // EN=0 with tvalid held: no handshake.
    axil_write(4'h0, 32'h0004_0000);
    @(negedge ACLK);
    s_axis_tdata = m_exp; s_axis_tvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("idle_tready", {31'b0, s_axis_tready}, 32'd0);
    end
    s_axis_tvalid = 0;
    axil_read(4'h8, "idle_beat");

    // CLR in the same cycle as an accepted beat: the beat is dropped.
    axil_write(4'h0, 32'h0004_0001);
    send_beat(m_exp, 0);
    send_beat(m_exp, 0);
    axil_read(4'h8, "pre_clr_beat");
    axil_write(4'h0, 32'h0004_0003, 1, m_exp);
    read_all("clr_beat");

    // Randomized rounds: random seed, length, occasional no-CLR and SEED-only rewrites.
    for (int r = 0; r < 8; r++) begin
      logic [15:0] len;
      logic [15:0] lens[4];
      lens[0] = 16'd0; lens[1] = 16'd3; lens[2] = 16'd5; lens[3] = 16'd8;
      len = lens[$urandom_range(0, 3)];
      axil_write(4'h4, $urandom);
      axil_write(4'h0, {len, 14'b0, (r == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1});
      for (int b = 0; b < int'($urandom_range(4, 20)); b++) send_random_beat();
      read_all("rand");
      check("rand_err_irq", {31'b0, err_irq}, {31'b0, (m_err != 0)});
    end

`ifdef AXIS_SINK_BACKPRESSURE_EN
    // Throttled stream: all 64 beats must land cleanly and tready must dip.
    saw_tready_low = 0;
    axil_write(4'h0, 32'h0008_0003);
    for (int i = 0; i < 64; i++) send_beat(m_exp, (i % 8) == 7, 3);
    axil_read(4'h8, "bp_beat");
    axil_read(4'hC, "bp_stat");
    check("bp_tready_low_seen", {31'b0, saw_tready_low}, 32'd1);
`endif

    // Reset mid-packet with an error pending.
    axil_write(4'h0, 32'h0008_0003);
    send_beat(m_exp, 0);
    send_beat(m_exp ^ 32'h10, 0);
    send_beat(m_exp, 0);
    repeat (2) @(negedge ACLK);
    check("pre_rst_err_irq", {31'b0, err_irq}, 32'd1);
    ARESETN = 0;
    #1;
    check("mid_rst_tready", {31'b0, s_axis_tready}, 32'd0);
    check("mid_rst_err_irq", {31'b0, err_irq}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1;
    model_reset();
    read_all("post_rst");

    repeat (4) @(negedge ACLK);
    check("sb_drained", sb_exp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
